freq_gen: RTL and testbench
===========================

// Module: freq_gen
// PURPOSE
//  Programmable square-wave generator; transmit-side counterpart of the frequency calculator.
//  Takes a target frequency in MHz (1..MAX_FREQ) over a valid/ready handshake.
//  Drives `signal` at that average frequency from the CLK_FREQ MHz system clock,
//  using a fractional phase accumulator.
//  Used as stimulus source for frequency-measurement blocks and as a general tone source.
// PARAMETERS
//  CLK_FREQ  100  system clock frequency in MHz
//  MAX_FREQ  50   highest accepted target (MHz); elaboration error if 2*MAX_FREQ > CLK_FREQ
//  FW        6    width of freq_in
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous reset, active low
//  freq_in     in   FW  requested frequency in MHz
//  freq_valid  in   1   freq_in valid
//  freq_ready  out  1   block can accept freq_in
//  start       in   1   1-cycle pulse: begin generation
//  stop        in   1   1-cycle pulse: end generation cleanly
//  signal      out  1   generated square wave (registered)
//  busy        out  1   state != IDLE
//  err         out  1   1-cycle pulse: rejected freq_in, or start with no frequency loaded
// BEHAVIOUR
//  Reset (async, rst_n=0): all regs cleared, state=IDLE.
//   - Outputs: signal=0, busy=0, err=0, freq_ready=1.
//   - Internal: freq_reg=0, acc=0, pend_vld=0.
//  States:
//   - IDLE -start, freq_reg!=0-> RUN
//   - RUN -stop-> STOP
//   - STOP -signal low-> IDLE
//   - start with freq_reg==0: err pulse, stay IDLE. start ignored outside IDLE.
//   - start and stop in same cycle: stop wins.
//  Handshake: transfer when freq_valid && freq_ready.
//   - Value range-checked on transfer.
//   - Legal range 1..MAX_FREQ. 0 or >MAX_FREQ: transfer completes, value dropped,
//     err=1 on next cycle, freq_reg unchanged.
//   - IDLE: legal value written to freq_reg next cycle.
//   - RUN/STOP: legal value goes to pend register, pend_vld=1, freq_ready=0.
//   - Pending value loads at the cycle signal toggles 1->0: freq_reg<=pend, acc<=0,
//     pend_vld<=0. No glitch or runt pulse on retune.
//  Generation, RUN and STOP, every clk:
//   - sum = acc + 2*freq_reg (8-bit unsigned, max 2*CLK_FREQ-1).
//   - sum >= CLK_FREQ: acc<=sum-CLK_FREQ and signal toggles. Else acc<=sum.
//   - Toggle registered: first toggle no earlier than cycle after entering RUN.
//   - Average period = CLK_FREQ/freq_reg clocks. Jitter <= 1 clk per edge.
//   - Integer divisors give exact periods.
//  Stop:
//   - Entering STOP with signal=0: IDLE next cycle.
//   - Otherwise continue accumulating until 1->0 toggle, then IDLE.
//   - On entering IDLE: acc cleared, signal=0. Pending value then loads into freq_reg.
//  Reset mid-operation: signal forced 0 immediately; pending value discarded.
// CONFIGURATION
//  FREQ_GEN_CYCLE_CNT_EN defined:
//   - Adds port cycle_cnt out 16.
//   - Increments on each 1->0 toggle of signal; wraps 0xFFFF->0.
//   - Cleared to 0 on reset and on accepted start.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. load 50, start -> signal toggles every clk (1,0,1,0..), period 2 clks, busy=1.
//  2. load 25, start -> 2 clks high, 2 clks low, repeating.
//  3. load 30, start -> exactly 6 toggles per 10 clks, acc sequence 60,20,80,40,0 repeating.
//  4. freq_in=0, then freq_in=51 -> err pulses 1 cycle each; a following load of 10 still works.
//  5. running at 50, send 10 -> freq_ready=0 until next 1->0 edge; then 5 clks high, 5 low.
//  6. stop while signal=1 -> one more falling edge, busy=0; rst_n low mid-run -> signal=0 at once.

Source files
------------

// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave generator driven by a
// fractional phase accumulator (average freq = freq_reg MHz).
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   freq_in/freq_valid    requested MHz, valid/ready handshake
//   freq_ready            low while a retune value is pending
//   start, stop           1-cycle control pulses (stop wins)
//   signal                registered square wave output
//   busy                  generator not idle
//   err                   1-cycle pulse on rejected value/start
//   cycle_cnt             falling-edge count, present only with
//                         FREQ_GEN_CYCLE_CNT_EN defined
module freq_gen #(
  parameter int CLK_FREQ = 100,
  parameter int MAX_FREQ = 50,
  parameter int FW       = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [FW-1:0] freq_in,
  input  logic          freq_valid,
  output logic          freq_ready,
  input  logic          start,
  input  logic          stop,
  output logic          signal,
  output logic          busy,
  output logic          err
`ifdef FREQ_GEN_CYCLE_CNT_EN
  ,
  output logic [15:0]   cycle_cnt
`endif
);

  localparam int AW = $clog2(2 * CLK_FREQ);

  if (2 * MAX_FREQ > CLK_FREQ) begin : g_bad_cfg
    $error("freq_gen: 2*MAX_FREQ exceeds CLK_FREQ");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [FW-1:0] r_freq;
  logic [FW-1:0] r_pend;
  logic          r_pend_vld;
  logic [AW-1:0] r_acc;
  logic          r_signal;
  logic          r_err;
`ifdef FREQ_GEN_CYCLE_CNT_EN
  logic [15:0]   r_cnt;
`endif

  logic          w_xfer;
  logic          w_legal;
  logic [AW-1:0] w_sum;
  logic          w_tog;
  logic          w_fall;
  logic          w_start;

  assign w_xfer  = freq_valid & ~r_pend_vld;
  assign w_legal = (freq_in != '0) &&
                   (freq_in <= FW'(MAX_FREQ));
  // Phase step is 2*f so one full cycle of the wave
  // spans two CLK_FREQ wraps (one per edge).
  assign w_sum   = r_acc + (AW'(r_freq) << 1);
  assign w_tog   = (w_sum >= AW'(CLK_FREQ));
  assign w_fall  = w_tog & r_signal;
  assign w_start = start & ~stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_freq     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_acc      <= '0;
      r_signal   <= 1'b0;
      r_err      <= 1'b0;
`ifdef FREQ_GEN_CYCLE_CNT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_err <= w_xfer & ~w_legal;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (r_freq != '0) begin
              r_state <= S_RUN;
`ifdef FREQ_GEN_CYCLE_CNT_EN
              r_cnt   <= '0;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
          // A value left pending by a short stop lands here.
          if (r_pend_vld) begin
            r_freq     <= r_pend;
            r_pend_vld <= 1'b0;
          end else if (w_xfer && w_legal) begin
            r_freq <= freq_in;
          end
        end
        S_RUN, S_STOP: begin
          if (r_state == S_STOP && !r_signal) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
          end else begin
            r_acc <= w_tog ? w_sum - AW'(CLK_FREQ)
                           : w_sum;
            if (w_tog) begin
              r_signal <= ~r_signal;
            end
            if (w_fall) begin
`ifdef FREQ_GEN_CYCLE_CNT_EN
              r_cnt <= r_cnt + 16'd1;
`endif
              // Retune only at a falling edge so the
              // low phase restarts cleanly from zero.
              if (r_pend_vld) begin
                r_freq     <= r_pend;
                r_pend_vld <= 1'b0;
                r_acc      <= '0;
              end
            end
            if (r_state == S_RUN && stop) begin
              r_state <= S_STOP;
            end else if (r_state == S_STOP && w_fall) begin
              r_state <= S_IDLE;
              r_acc   <= '0;
            end
          end
          if (w_xfer && w_legal) begin
            r_pend     <= freq_in;
            r_pend_vld <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign freq_ready = ~r_pend_vld;
  assign signal     = r_signal;
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;
`ifdef FREQ_GEN_CYCLE_CNT_EN
  assign cycle_cnt  = r_cnt;
`endif

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: random + directed stimulus for freq_gen,
// scoreboarded against a closed-form phase model.
module tb_freq_gen;

  localparam int CLK = 100;
  localparam int MAXF = 50;
  localparam int FW = 6;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] freq_in;
  logic          freq_valid;
  logic          freq_ready;
  logic          start;
  logic          stop;
  logic          signal;
  logic          busy;
  logic          err;
`ifdef FREQ_GEN_CYCLE_CNT_EN
  logic [15:0]   cycle_cnt;
`endif

  freq_gen #(
    .CLK_FREQ(CLK),
    .MAX_FREQ(MAXF),
    .FW(FW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .freq_in(freq_in),
    .freq_valid(freq_valid),
    .freq_ready(freq_ready),
    .start(start),
    .stop(stop),
    .signal(signal),
    .busy(busy),
    .err(err)
`ifdef FREQ_GEN_CYCLE_CNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit sig;
    bit bsy;
    bit er;
    bit rdy;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Model state: mode 0 idle, 1 run, 2 stopping.
  int m_mode, m_f, m_pend, m_n, m_cnt;
  bit m_pv, m_sig;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Wave level after n cycles at f MHz is the parity of
  // the number of half-periods elapsed: floor(n*2f/CLK).
  task automatic model_step();
    exp_t e;
    bit   xfer, legal, fall;
    int   fin, old_mode;
    e.er = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_f = 0; m_pend = 0; m_pv = 0;
      m_sig = 0; m_n = 0; m_cnt = 0;
    end else begin
      fin = int'(freq_in);
      xfer = freq_valid && !m_pv;
      legal = (fin >= 1) && (fin <= MAXF);
      if (xfer && !legal) e.er = 1'b1;
      old_mode = m_mode;
      if (m_mode == 0) begin
        if (start && !stop) begin
          if (m_f != 0) begin
            m_mode = 1; m_n = 0; m_cnt = 0;
          end else begin
            e.er = 1'b1;
          end
        end
        if (m_pv) begin
          m_f = m_pend; m_pv = 0;
        end else if (xfer && legal) begin
          m_f = fin;
        end
      end else if (m_mode == 2 && !m_sig) begin
        m_mode = 0;
      end else begin
        m_n++;
        fall = m_sig && (((m_n * 2 * m_f) / CLK) % 2 == 0);
        m_sig = (((m_n * 2 * m_f) / CLK) % 2) != 0;
        if (fall) begin
          m_cnt = (m_cnt + 1) % 65536;
          if (m_pv) begin
            m_f = m_pend; m_pv = 0; m_n = 0;
          end
        end
        if (m_mode == 1 && stop) m_mode = 2;
        else if (m_mode == 2 && fall) m_mode = 0;
      end
      if (old_mode != 0 && xfer && legal) begin
        m_pend = fin; m_pv = 1;
      end
    end
    e.sig = m_sig;
    e.bsy = (m_mode != 0);
    e.rdy = !m_pv;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: outputs settle after the edge; compare on
  // the falling edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        e = q.pop_front();
        chk("signal", int'(signal), int'(e.sig));
        chk("busy", int'(busy), int'(e.bsy));
        chk("err", int'(err), int'(e.er));
        chk("freq_ready", int'(freq_ready), int'(e.rdy));
`ifdef FREQ_GEN_CYCLE_CNT_EN
        chk("cycle_cnt", int'(cycle_cnt), e.cnt);
`endif
      end
    end
  end

  task automatic drive(input bit v, input int fin,
                       input bit s, input bit p);
    logic [31:0] f32;
    @(negedge clk);
    #1;
    f32 = fin;
    freq_valid = v;
    freq_in = f32[FW-1:0];
    start = s;
    stop = p;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(0, 0, 0, 0);
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    #1;
    freq_valid = 0; start = 0; stop = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_signal", int'(signal), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(freq_ready), 1);
    chk("rst_err", int'(err), 0);
    repeat (k) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    freq_in = '0;
    freq_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    do_reset(3);
    // start with nothing loaded
    drive(0, 0, 1, 0); idle(2);
    // 50 MHz: toggles every clock
    drive(1, 50, 0, 0); drive(0, 0, 1, 0);
    idle(10); drive(0, 0, 0, 1); idle(4);
    // 25 MHz: 2 high, 2 low
    drive(1, 25, 0, 0); drive(0, 0, 1, 0);
    idle(12); drive(0, 0, 0, 1); idle(6);
    // 30 MHz: fractional, 6 toggles per 10 clocks
    drive(1, 30, 0, 0); drive(0, 0, 1, 0);
    idle(20); drive(0, 0, 0, 1); idle(6);
    // rejected values, then a good one
    drive(1, 0, 0, 0); idle(1);
    drive(1, 51, 0, 0); idle(1);
    drive(1, 63, 0, 0); idle(1);
    drive(1, 10, 0, 0); drive(0, 0, 1, 0);
    idle(25); drive(0, 0, 0, 1); idle(12);
    // retune while running at 50 -> 10
    drive(1, 50, 0, 0); drive(0, 0, 1, 0);
    idle(5); drive(1, 10, 0, 0);
    drive(1, 20, 0, 0); idle(30);
    drive(0, 0, 0, 1); idle(15);
    // start+stop together: stop wins
    drive(0, 0, 1, 1); idle(3);
    // stop while high, then reset mid-run
    drive(1, 25, 0, 0); drive(0, 0, 1, 0);
    idle(1); drive(0, 0, 0, 1); idle(6);
    drive(1, 40, 0, 0); drive(0, 0, 1, 0); idle(7);
    drive(1, 17, 0, 0); idle(1);
    do_reset(2);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit v, s, p;
      int f;
      v = ($urandom % 6) == 0;
      if (($urandom % 5) == 0) f = $urandom % 64;
      else f = 1 + ($urandom % MAXF);
      s = ($urandom % 12) == 0;
      p = ($urandom % 30) == 0;
      drive(v, f, s, p);
      if (($urandom % 700) == 0) do_reset(1);
    end
    idle(3);
    @(negedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
